// File: rtl/mem_port_arbiter_if.sv
// Line-wide request/response bundles: cache <-> arbiter and arbiter <-> DataMemory.
interface cache_line_if #(
  parameter int unsigned LINE_SIZE = 16
);
  logic                   req;
  logic                   we;
  logic [31:0]            addr;
  logic [8*LINE_SIZE-1:0] wdata;
  logic                   done;
  logic [8*LINE_SIZE-1:0] rdata;

  modport master (output req, we, addr, wdata, input done, rdata);
  modport slave  (input req, we, addr, wdata, output done, rdata);
endinterface

interface mem_line_if #(
  parameter int unsigned LINE_SIZE = 16
);
  logic                   is_input_valid;
  logic                   mem_read;
  logic                   mem_write;
  logic [31:0]            addr;
  logic [8*LINE_SIZE-1:0] din;
  logic                   is_output_valid;
  logic [8*LINE_SIZE-1:0] dout;
  logic                   mem_ready;

  modport master (output is_input_valid, mem_read, mem_write, addr, din,
                  input  is_output_valid, dout, mem_ready);
  modport slave  (input  is_input_valid, mem_read, mem_write, addr, din,
                  output is_output_valid, dout, mem_ready);
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one line-wide DataMemory port between I- and D-cache,
// with per-side grant counters and a sticky wait timeout.
module mem_port_arbiter #(
  parameter int unsigned LINE_SIZE = 16,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic        clk,
  input  logic        reset,
  cache_line_if.slave i_port,
  cache_line_if.slave d_port,
  mem_line_if.master  m_port,
  output logic [31:0] i_grant_count,
  output logic [31:0] d_grant_count,
  output logic        timeout_err
);
  localparam int unsigned LINE_W = 8 * LINE_SIZE;
  localparam int unsigned OFF_W  = $clog2(LINE_SIZE);
  localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RD, WAIT_WR, DONE} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d, we_q, we_d, last_q, last_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic              valid_q, valid_d, rd_q, rd_d, wr_q, wr_d;
  logic [31:0]       maddr_q, maddr_d;
  logic [LINE_W-1:0] mdin_q, mdin_d, irdata_q, irdata_d, drdata_q, drdata_d;
  logic              idone_q, idone_d, ddone_q, ddone_d;
  logic [31:0]       icnt_q, icnt_d, dcnt_q, dcnt_d;
  logic              err_q, err_d;
  logic              finish, timed_out;

  logic              pick_d;
  logic              sel_we;
  logic [31:0]       sel_addr;
  logic [LINE_W-1:0] sel_wdata;
  logic              expired;
  logic [CNT_W-1:0]  wait_inc;

  // D wins a tie only when I was the previous owner
  assign pick_d    = d_port.req & (~i_port.req | (last_q == OWN_I));
  assign sel_we    = pick_d ? d_port.we    : i_port.we;
  assign sel_addr  = pick_d ? d_port.addr  : i_port.addr;
  assign sel_wdata = pick_d ? d_port.wdata : i_port.wdata;
  assign expired   = (wait_q >= CNT_LAST);
  assign wait_inc  = (wait_q < CNT_MAX) ? wait_q + CNT_W'(1) : wait_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      owner_q  <= OWN_I;
      we_q     <= 1'b0;
      last_q   <= OWN_I;
      wait_q   <= '0;
      valid_q  <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      maddr_q  <= '0;
      mdin_q   <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
      idone_q  <= 1'b0;
      ddone_q  <= 1'b0;
      icnt_q   <= '0;
      dcnt_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      last_q   <= last_d;
      wait_q   <= wait_d;
      valid_q  <= valid_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      maddr_q  <= maddr_d;
      mdin_q   <= mdin_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
      idone_q  <= idone_d;
      ddone_q  <= ddone_d;
      icnt_q   <= icnt_d;
      dcnt_q   <= dcnt_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    last_d    = last_q;
    wait_d    = wait_q;
    valid_d   = valid_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    maddr_d   = maddr_q;
    mdin_d    = mdin_q;
    irdata_d  = irdata_q;
    drdata_d  = drdata_q;
    idone_d   = 1'b0;
    ddone_d   = 1'b0;
    icnt_d    = icnt_q;
    dcnt_d    = dcnt_q;
    err_d     = err_q;
    finish    = 1'b0;
    timed_out = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_port.req | d_port.req) begin
          owner_d = pick_d;
          we_d    = sel_we;
          maddr_d = sel_addr >> OFF_W;
          mdin_d  = sel_wdata;
          valid_d = 1'b1;
          rd_d    = ~sel_we;
          wr_d    = sel_we;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wait_d = wait_inc;
        if (m_port.mem_ready) begin
          valid_d = 1'b0;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = we_q ? WAIT_WR : WAIT_RD;
        end else if (expired) begin
          timed_out = 1'b1;
        end
      end
      WAIT_RD: begin
        wait_d = wait_inc;
        if (m_port.is_output_valid) begin
          finish = 1'b1;
          if (owner_q == OWN_D) drdata_d = m_port.dout;
          else                  irdata_d = m_port.dout;
        end else if (expired) begin
          timed_out = 1'b1;
        end
      end
      WAIT_WR: begin
        wait_d = wait_inc;
        if (m_port.mem_ready) finish = 1'b1;
        else if (expired)     timed_out = 1'b1;
      end
      DONE: begin
        if (owner_q == OWN_D) dcnt_d = dcnt_q + 32'd1;
        else                  icnt_d = icnt_q + 32'd1;
        last_d   = owner_q;
        wait_d   = '0;
        irdata_d = '0;
        drdata_d = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Timeout abandons the memory request but still completes to the owner
    if (timed_out) begin
      err_d   = 1'b1;
      valid_d = 1'b0;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      finish  = 1'b1;
    end
    if (finish) begin
      state_d = DONE;
      if (owner_q == OWN_D) ddone_d = 1'b1;
      else                  idone_d = 1'b1;
    end
  end

  assign i_port.done           = idone_q;
  assign i_port.rdata          = irdata_q;
  assign d_port.done           = ddone_q;
  assign d_port.rdata          = drdata_q;
  assign m_port.is_input_valid = valid_q;
  assign m_port.mem_read       = rd_q;
  assign m_port.mem_write      = wr_q;
  assign m_port.addr           = maddr_q;
  assign m_port.din            = mdin_q;
  assign i_grant_count         = icnt_q;
  assign d_grant_count         = dcnt_q;
  assign timeout_err           = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: arbitration order, handshakes, reset and timeout.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int unsigned LINE_SIZE = 16;
  localparam int unsigned LW = 8 * LINE_SIZE;
  typedef logic [LW-1:0] line_t;

  localparam line_t LINE_A = {4{32'h1111_2222}};
  localparam line_t LINE_B = {4{32'hBBBB_0001}};
  localparam line_t LINE_C = {4{32'h0123_4567}};
  localparam line_t LINE_D = {4{32'hD00D_FEED}};
  localparam line_t LINE_5 = {16{8'hA5}};

  logic clk = 1'b0;
  logic reset;
  logic [31:0] i_cnt, d_cnt, t_i_cnt, t_d_cnt;
  logic err, t_err;
  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  int lat;

  cache_line_if #(.LINE_SIZE(LINE_SIZE)) i_if ();
  cache_line_if #(.LINE_SIZE(LINE_SIZE)) d_if ();
  mem_line_if   #(.LINE_SIZE(LINE_SIZE)) m_if ();
  cache_line_if #(.LINE_SIZE(LINE_SIZE)) t_i_if ();
  cache_line_if #(.LINE_SIZE(LINE_SIZE)) t_d_if ();
  mem_line_if   #(.LINE_SIZE(LINE_SIZE)) t_m_if ();

  mem_port_arbiter #(.LINE_SIZE(LINE_SIZE)) dut (
    .clk(clk), .reset(reset), .i_port(i_if), .d_port(d_if), .m_port(m_if),
    .i_grant_count(i_cnt), .d_grant_count(d_cnt), .timeout_err(err)
  );

  mem_port_arbiter #(.LINE_SIZE(LINE_SIZE), .TIMEOUT(8)) dut_to (
    .clk(clk), .reset(reset), .i_port(t_i_if), .d_port(t_d_if), .m_port(t_m_if),
    .i_grant_count(t_i_cnt), .d_grant_count(t_d_cnt), .timeout_err(t_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin n_fail++; $error("FAIL %s: observed %b expected %b", tag, obs, exp); end
  endtask

  task automatic check_w32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin n_fail++; $error("FAIL %s: observed %0h expected %0h", tag, obs, exp); end
  endtask

  task automatic check_line(input string tag, input line_t obs, input line_t exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin n_fail++; $error("FAIL %s: observed %h expected %h", tag, obs, exp); end
  endtask

  task automatic wait_issue(input string tag);
    int n = 0;
    while (!m_if.is_input_valid && n < 20) begin tick(); n++; end
    check_bit({tag, " issued"}, m_if.is_input_valid, 1'b1);
  endtask

  // Read transaction with memory ready at once and data returned `lt` edges after acceptance
  task automatic serve_read(input string tag, input logic exp_d, input logic [31:0] exp_maddr,
                            input int lt, input line_t data);
    wait_issue(tag);
    check_w32({tag, " m_addr"}, m_if.addr, exp_maddr);
    check_bit({tag, " m_mem_read"}, m_if.mem_read, 1'b1);
    check_bit({tag, " m_mem_write"}, m_if.mem_write, 1'b0);
    tick();
    check_bit({tag, " valid cleared"}, m_if.is_input_valid, 1'b0);
    repeat (lt - 1) tick();
    check_bit({tag, " no early done"}, i_if.done | d_if.done, 1'b0);
    m_if.is_output_valid = 1'b1;
    m_if.dout = data;
    tick();
    m_if.is_output_valid = 1'b0;
    m_if.dout = '0;
    check_bit({tag, " i_done"}, i_if.done, ~exp_d);
    check_bit({tag, " d_done"}, d_if.done, exp_d);
    check_line({tag, " i_rdata"}, i_if.rdata, exp_d ? '0 : data);
    check_line({tag, " d_rdata"}, d_if.rdata, exp_d ? data : '0);
    if (exp_d) d_if.req = 1'b0;
    else       i_if.req = 1'b0;
    tick();
    check_bit({tag, " done one cycle"}, i_if.done | d_if.done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    i_if.req = 0; i_if.we = 0; i_if.addr = '0; i_if.wdata = '0;
    d_if.req = 0; d_if.we = 0; d_if.addr = '0; d_if.wdata = '0;
    m_if.is_output_valid = 0; m_if.dout = '0; m_if.mem_ready = 1;
    t_i_if.req = 0; t_i_if.we = 0; t_i_if.addr = '0; t_i_if.wdata = '0;
    t_d_if.req = 0; t_d_if.we = 0; t_d_if.addr = '0; t_d_if.wdata = '0;
    t_m_if.is_output_valid = 0; t_m_if.dout = '0; t_m_if.mem_ready = 1;
    repeat (3) tick();

    check_bit("rst m_is_input_valid", m_if.is_input_valid, 1'b0);
    check_bit("rst m_mem_read", m_if.mem_read, 1'b0);
    check_bit("rst done", i_if.done | d_if.done, 1'b0);
    check_bit("rst timeout_err", err, 1'b0);
    check_w32("rst i_grant_count", i_cnt, 32'd0);
    check_w32("rst m_addr", m_if.addr, 32'd0);
    check_line("rst m_din", m_if.din, '0);
    reset = 1'b1;
    tick();

    // Single I read, 5-cycle memory latency
    i_if.req = 1; i_if.we = 0; i_if.addr = 32'h0000_0040;
    serve_read("t1", 1'b0, 32'h4, 5, LINE_A);
    check_w32("t1 i_grant_count", i_cnt, 32'd1);
    check_w32("t1 d_grant_count", d_cnt, 32'd0);

    // Simultaneous requests after reset alternate starting with D
    reset = 1'b0; tick(); reset = 1'b1; tick();
    i_if.req = 1; i_if.we = 0; i_if.addr = 32'h40;
    d_if.req = 1; d_if.we = 0; d_if.addr = 32'h200;
    for (int k = 0; k < 4; k++) begin
      serve_read($sformatf("alt%0d D", k), 1'b1, 32'h20, 1, {4{32'hD000_0000 + 32'(k)}});
      if (k < 3) d_if.req = 1'b1;
      serve_read($sformatf("alt%0d I", k), 1'b0, 32'h4, 2, {4{32'h1000_0000 + 32'(k)}});
      if (k < 3) i_if.req = 1'b1;
    end
    check_w32("alt i_grant_count", i_cnt, 32'd4);
    check_w32("alt d_grant_count", d_cnt, 32'd4);

    // D writeback wins over pending I refill; completes only once ready returns
    d_if.req = 1; d_if.we = 1; d_if.addr = 32'h100; d_if.wdata = LINE_5;
    i_if.req = 1; i_if.we = 0; i_if.addr = 32'h80;
    wait_issue("t3");
    check_bit("t3 m_mem_write", m_if.mem_write, 1'b1);
    check_bit("t3 m_mem_read", m_if.mem_read, 1'b0);
    check_w32("t3 m_addr", m_if.addr, 32'h10);
    check_line("t3 m_din", m_if.din, LINE_5);
    tick();
    m_if.mem_ready = 0;
    repeat (3) begin
      tick();
      check_bit("t3 d_done while not ready", d_if.done, 1'b0);
    end
    m_if.mem_ready = 1;
    tick();
    check_bit("t3 d_done", d_if.done, 1'b1);
    check_bit("t3 i_done", i_if.done, 1'b0);
    check_line("t3 d_rdata on write", d_if.rdata, '0);
    d_if.req = 0; d_if.we = 0;
    tick();
    check_w32("t3 d_grant_count", d_cnt, 32'd5);
    serve_read("t3 I", 1'b0, 32'h8, 3, LINE_B);
    check_w32("t3 i_grant_count", i_cnt, 32'd5);

    // Backpressure: request held stable for 10 not-ready cycles
    m_if.mem_ready = 0;
    d_if.req = 1; d_if.we = 1; d_if.addr = 32'h3C0; d_if.wdata = LINE_C;
    wait_issue("t4");
    for (int k = 0; k < 10; k++) begin
      check_bit($sformatf("t4 valid held %0d", k), m_if.is_input_valid, 1'b1);
      check_w32($sformatf("t4 m_addr %0d", k), m_if.addr, 32'h3C);
      check_line($sformatf("t4 m_din %0d", k), m_if.din, LINE_C);
      tick();
    end
    m_if.mem_ready = 1;
    check_bit("t4 valid before accept", m_if.is_input_valid, 1'b1);
    tick();
    check_bit("t4 valid after accept", m_if.is_input_valid, 1'b0);
    m_if.mem_ready = 0;
    tick();
    check_bit("t4 no duplicate request", m_if.is_input_valid, 1'b0);
    check_bit("t4 d_done early", d_if.done, 1'b0);
    m_if.mem_ready = 1;
    tick();
    check_bit("t4 d_done", d_if.done, 1'b1);
    d_if.req = 0; d_if.we = 0;
    tick();
    check_w32("t4 d_grant_count", d_cnt, 32'd6);

    // Reset two cycles into read latency
    d_if.req = 1; d_if.we = 0; d_if.addr = 32'h500;
    wait_issue("t5");
    tick(); tick(); tick();
    reset = 1'b0;
    #1;
    check_w32("t5 async m_addr", m_if.addr, 32'd0);
    check_w32("t5 async i_grant_count", i_cnt, 32'd0);
    check_w32("t5 async d_grant_count", d_cnt, 32'd0);
    check_bit("t5 async d_done", d_if.done, 1'b0);
    d_if.req = 0;
    tick(); tick();
    check_bit("t5 no done in reset", d_if.done, 1'b0);
    reset = 1'b1;
    tick();
    d_if.req = 1; d_if.addr = 32'h500;
    serve_read("t5 after", 1'b1, 32'h50, 1, LINE_D);
    check_w32("t5 d_grant_count", d_cnt, 32'd1);
    check_w32("t5 i_grant_count", i_cnt, 32'd0);

    // Timeout (TIMEOUT=8): memory never returns read data
    check_bit("t6 err before", t_err, 1'b0);
    t_i_if.req = 1; t_i_if.we = 0; t_i_if.addr = 32'h40;
    lat = 0;
    do begin
      tick();
      lat++;
      if (lat == 8) check_bit("t6 err before expiry", t_err, 1'b0);
    end while (!t_i_if.done && lat < 30);
    check_w32("t6 done latency", 32'(lat), 32'd9);
    check_bit("t6 timeout_err", t_err, 1'b1);
    check_line("t6 i_rdata", t_i_if.rdata, '0);
    check_bit("t6 m valid cleared", t_m_if.is_input_valid, 1'b0);
    t_i_if.req = 0;
    tick();
    check_bit("t6 err sticky", t_err, 1'b1);
    check_w32("t6 i_grant_count", t_i_cnt, 32'd1);
    t_d_if.req = 1; t_d_if.we = 0; t_d_if.addr = 32'h80;
    tick();
    check_bit("t6 next issued", t_m_if.is_input_valid, 1'b1);
    check_w32("t6 next m_addr", t_m_if.addr, 32'h8);
    tick();
    t_m_if.is_output_valid = 1; t_m_if.dout = LINE_D;
    tick();
    t_m_if.is_output_valid = 0; t_m_if.dout = '0;
    check_bit("t6 next d_done", t_d_if.done, 1'b1);
    check_line("t6 next d_rdata", t_d_if.rdata, LINE_D);
    t_d_if.req = 0;
    tick();
    check_w32("t6 d_grant_count", t_d_cnt, 32'd1);
    check_bit("t6 err still sticky", t_err, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
